modulo_buffer_principal_rolhas: RTL and testbench

MODULO_BUFFER_PRINCIPAL_ROLHAS -- requirements
Module: modulo_buffer_principal_rolhas

---
 rtl/modulo_buffer_principal_rolhas_if.sv | 21 ++
 rtl/modulo_buffer_principal_rolhas.sv | 137 +++++++++++++
 tb/tb_modulo_buffer_principal_rolhas.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/modulo_buffer_principal_rolhas_if.sv
// -----------------------------------------------------------------------------
// modulo_buffer_principal_rolhas_if
// Purpose : cork-transfer handshake between the secondary buffer (master,
//           offers corks) and the main buffer (slave, accepts corks).
// Signals : transf_valid - secondary buffer offers one cork this cycle
//           transf_ready - main buffer accepts one cork this cycle
// -----------------------------------------------------------------------------
interface modulo_buffer_principal_rolhas_if;
  logic transf_valid;
  logic transf_ready;

  modport master (
    output transf_valid,
    input  transf_ready
  );

  modport slave (
    input  transf_valid,
    output transf_ready
  );
endinterface

// File: rtl/modulo_buffer_principal_rolhas.sv
// -----------------------------------------------------------------------------
// modulo_buffer_principal_rolhas
// Purpose : main cork buffer of the sealing station. Counts corks, accepts
//           refills from the secondary buffer, consumes one cork per rising
//           edge of the sealing valve and requests refills below a threshold.
// Ports   : clk            - clock, rising edge
//           clr            - asynchronous active-low reset
//           enable         - 0 freezes count, FSM and valve edge detector
//           ve             - sealing-valve level, one cork per rising edge
//           clr_err        - synchronous clear of err_consumo
//           transf         - valid/ready cork transfer (slave side)
//           buffer_principal - current cork count
//           ro / min_signal / cheio - empty / above-threshold / full decodes
//           pedido_transf  - registered refill request
//           err_consumo    - sticky "sealed on empty buffer" flag
//           estado         - FSM state (NORMAL=00, REABASTECENDO=01, VAZIO=10)
// -----------------------------------------------------------------------------
module modulo_buffer_principal_rolhas #(
  parameter int MAX_ROLHAS  = 99,
  parameter int MIN_ROLHAS  = 5,
  parameter int ALVO_ROLHAS = 20
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       ve,
  input  logic       clr_err,
  modulo_buffer_principal_rolhas_if.slave transf,
  output logic [6:0] buffer_principal,
  output logic       ro,
  output logic       min_signal,
  output logic       pedido_transf,
  output logic       cheio,
  output logic       err_consumo,
  output logic [1:0] estado
);

  typedef enum logic [1:0] {
    NORMAL        = 2'b00,
    REABASTECENDO = 2'b01,
    VAZIO         = 2'b10
  } estado_t;

  localparam logic [6:0] MAX_C  = 7'(MAX_ROLHAS);
  localparam logic [6:0] MIN_C  = 7'(MIN_ROLHAS);
  localparam logic [6:0] ALVO_C = 7'(ALVO_ROLHAS);

  logic [6:0] count_q, count_d;
  estado_t    state_q, state_d;
  logic       ve_q, ve_d;
  logic       err_q, err_d;
  logic       pedido_q;

  logic       accept;
  logic       consume;
  logic       consume_ok;

  // Ready only while refilling and not full; enable gates it too.
  assign transf.transf_ready = enable
                             && (state_q == REABASTECENDO || state_q == VAZIO)
                             && (count_q < MAX_C);

  assign accept     = transf.transf_valid && transf.transf_ready;
  // Edge detect on the valve: a long level still consumes only one cork.
  assign consume    = enable && ve && !ve_q;
  assign consume_ok = consume && (count_q != 7'd0);

  // Count, valve register and error flag next-state.
  always_comb begin
    count_d = count_q;
    ve_d    = ve_q;
    err_d   = err_q;

    if (clr_err) err_d = 1'b0;

    if (enable) begin
      ve_d = ve;
      // Set after clear so a simultaneous new error wins.
      if (consume && count_q == 7'd0) err_d = 1'b1;

      // accept already guarantees count_q < MAX, so +1 never overflows;
      // a simultaneous accept and valid consume cancel out.
      if (accept && !consume_ok)      count_d = count_q + 7'd1;
      else if (consume_ok && !accept) count_d = count_q - 7'd1;
    end
  end

  // FSM next-state, decided on the count that will be stored this edge.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      if (count_d == 7'd0) begin
        state_d = VAZIO;
      end else begin
        unique case (state_q)
          NORMAL: begin
            if (count_d <= MIN_C) state_d = REABASTECENDO;
          end
          REABASTECENDO: begin
            if (count_d >= ALVO_C) state_d = NORMAL;
          end
          VAZIO: begin
            // A non-zero next count from empty can only come from a transfer.
            if (accept) state_d = REABASTECENDO;
          end
          default: state_d = VAZIO;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q  <= 7'd0;
      state_q  <= VAZIO;
      ve_q     <= 1'b0;
      err_q    <= 1'b0;
      pedido_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      state_q  <= state_d;
      ve_q     <= ve_d;
      err_q    <= err_d;
      // Registered from the next state so it tracks estado exactly.
      pedido_q <= (state_d != NORMAL);
    end
  end

  assign buffer_principal = count_q;
  assign estado           = state_q;
  assign pedido_transf    = pedido_q;
  assign err_consumo      = err_q;
  assign ro               = (count_q == 7'd0);
  assign min_signal       = (count_q > MIN_C);
  assign cheio            = (count_q == MAX_C);

endmodule

// File: tb/tb_modulo_buffer_principal_rolhas.sv
module tb_modulo_buffer_principal_rolhas;

  logic clk = 1'b0;
  logic clr, enable, ve, clr_err, ve2;

  logic [6:0] count1, count2;
  logic ro1, min1, ped1, cheio1, err1;
  logic ro2, min2, ped2, cheio2, err2;
  logic [1:0] est1, est2;

  int n_checks = 0;
  int n_fail   = 0;

  modulo_buffer_principal_rolhas_if bus1_if ();
  modulo_buffer_principal_rolhas_if bus2_if ();

  always #5 clk = ~clk;

  modulo_buffer_principal_rolhas dut (
    .clk(clk), .clr(clr), .enable(enable), .ve(ve), .clr_err(clr_err),
    .transf(bus1_if.slave),
    .buffer_principal(count1), .ro(ro1), .min_signal(min1),
    .pedido_transf(ped1), .cheio(cheio1), .err_consumo(err1), .estado(est1)
  );

  modulo_buffer_principal_rolhas #(
    .MAX_ROLHAS(21), .MIN_ROLHAS(5), .ALVO_ROLHAS(21)
  ) dut_full (
    .clk(clk), .clr(clr), .enable(enable), .ve(ve2), .clr_err(clr_err),
    .transf(bus2_if.slave),
    .buffer_principal(count2), .ro(ro2), .min_signal(min2),
    .pedido_transf(ped2), .cheio(cheio2), .err_consumo(err2), .estado(est2)
  );

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t valid=%0b ve=%0b count=%0d estado=%0d pedido=%0b err=%0b",
             $time, bus1_if.transf_valid, ve, count1, est1, ped1, err1);
  endtask

  task automatic ve_pulse();
    ve = 1'b1; tick();
    ve = 1'b0; tick();
  endtask

  initial begin
    clr = 1'b0; enable = 1'b1; ve = 1'b0; ve2 = 1'b0; clr_err = 1'b0;
    bus1_if.transf_valid = 1'b0;
    bus2_if.transf_valid = 1'b0;
    #12;
    // Reset state
    check_val("rst_count", count1, 0);
    check_val("rst_estado", est1, 2);
    check_val("rst_pedido", ped1, 1);
    check_val("rst_err", err1, 0);
    check_val("rst_ro", ro1, 1);
    check_val("rst_min", min1, 0);
    check_val("rst_cheio", cheio1, 0);

    @(posedge clk); #1;
    clr = 1'b1;
    bus1_if.transf_valid = 1'b1;
    bus2_if.transf_valid = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 1) begin
        check_val("fill1_count", count1, 1);
        check_val("fill1_estado", est1, 1);
      end
      if (i == 20) begin
        check_val("fill20_count", count1, 20);
        check_val("fill20_estado", est1, 0);
        check_val("fill20_pedido", ped1, 0);
      end
    end
    check_val("fill25_count", count1, 20);
    check_val("fill25_ready", bus1_if.transf_ready, 0);
    check_val("fill25_pedido", ped1, 0);
    check_val("full_count", count2, 21);
    check_val("full_cheio", cheio2, 1);
    check_val("full_ready", bus2_if.transf_ready, 0);
    bus1_if.transf_valid = 1'b0;
    bus2_if.transf_valid = 1'b0;

    // Consume 20 -> 6
    for (int i = 0; i < 14; i++) ve_pulse();
    check_val("c6_count", count1, 6);
    check_val("c6_estado", est1, 0);
    check_val("c6_min", min1, 1);

    // Threshold crossing 6 -> 5
    ve = 1'b1; tick();
    check_val("c5_count", count1, 5);
    check_val("c5_estado", est1, 1);
    check_val("c5_pedido", ped1, 1);
    check_val("c5_min", min1, 0);
    ve = 1'b0; tick();

    // Long valve level -> one decrement
    ve = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_val("hold_count", count1, 4);
    ve = 1'b0; tick();

    // Transfer and consume together -> unchanged
    bus1_if.transf_valid = 1'b1; ve = 1'b1;
    #1 check_val("both_ready", bus1_if.transf_ready, 1);
    tick();
    check_val("both_count", count1, 4);
    bus1_if.transf_valid = 1'b0; ve = 1'b0;
    tick();

    // Drain to empty
    for (int i = 0; i < 4; i++) ve_pulse();
    check_val("empty_count", count1, 0);
    check_val("empty_estado", est1, 2);
    check_val("empty_ro", ro1, 1);
    check_val("empty_err", err1, 0);

    // Consume on empty
    ve = 1'b1; tick();
    check_val("err_count", count1, 0);
    check_val("err_set", err1, 1);
    ve = 1'b0; tick();
    tick();
    check_val("err_sticky", err1, 1);
    clr_err = 1'b1; ve = 1'b1; tick();
    check_val("err_setwins", err1, 1);
    ve = 1'b0; tick();
    check_val("err_cleared", err1, 0);
    clr_err = 1'b0;

    // Enable low freezes everything
    enable = 1'b0; bus1_if.transf_valid = 1'b1;
    #1 check_val("dis_ready", bus1_if.transf_ready, 0);
    tick();
    check_val("dis_count", count1, 0);
    enable = 1'b1;

    // Refill to 12, then asynchronous reset mid-refill
    for (int i = 0; i < 12; i++) tick();
    check_val("r12_count", count1, 12);
    check_val("r12_estado", est1, 1);
    #2 clr = 1'b0;
    #1;
    check_val("arst_count", count1, 0);
    check_val("arst_estado", est1, 2);
    check_val("arst_pedido", ped1, 1);
    check_val("arst_ro", ro1, 1);
    check_val("arst_min", min1, 0);
    bus1_if.transf_valid = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    check_val("post_rst_count", count1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
